// File: rtl/pc_unit_if.sv
// pc_unit_if: redirect/stall inputs and PC status outputs of the program-counter stage.
// Optional return-address-stack signals exist only when PC_RAS_EN is defined.
interface pc_unit_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
);
  logic             stall;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump_valid;
  logic [WIDTH-1:0] jump_target;
  logic             trap;
  logic [WIDTH-1:0] pc_out;
  logic             pc_valid;
  logic             misaligned;
  logic [CNT_W-1:0] pc_count;
`ifdef PC_RAS_EN
  logic             is_call;
  logic             is_ret;
  logic             ras_underflow;

  modport master (
    output stall, branch_taken, branch_target, jump_valid, jump_target, trap,
           is_call, is_ret,
    input  pc_out, pc_valid, misaligned, pc_count, ras_underflow
  );
  modport slave (
    input  stall, branch_taken, branch_target, jump_valid, jump_target, trap,
           is_call, is_ret,
    output pc_out, pc_valid, misaligned, pc_count, ras_underflow
  );
`else
  modport master (
    output stall, branch_taken, branch_target, jump_valid, jump_target, trap,
    input  pc_out, pc_valid, misaligned, pc_count
  );
  modport slave (
    input  stall, branch_taken, branch_target, jump_valid, jump_target, trap,
    output pc_out, pc_valid, misaligned, pc_count
  );
`endif
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program-counter stage with next-PC selection (trap > jump > branch >
// stall > increment), misaligned-target trapping and a saturating advance counter.
// Optional feature macro PC_RAS_EN adds a circular return-address stack that
// supplies return targets for jumps qualified with is_ret.
module pc_unit #(
  parameter int               WIDTH        = 64,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 64'h0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 64'h100,
  parameter int               STEP         = 4,
  parameter int               CNT_W        = 32,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic      clk,
  input  logic      reset,
  pc_unit_if.slave  bus
);

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RAS_DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] pc_reg;
  logic             valid_reg;
  logic             mis_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0] step_pc;
  logic [WIDTH-1:0] jump_tgt;
  logic [WIDTH-1:0] sel_tgt;
  logic             check_tgt;
  logic [WIDTH-1:0] pc_next;
  logic             mis_next;
  logic             write_pc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign step_pc = pc_reg + WIDTH'(STEP);

`ifdef PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W:0]   ras_cnt;
  logic [PTR_W-1:0] ras_ptr_next;
  logic [PTR_W:0]   ras_cnt_next;
  logic [PTR_W-1:0] push_idx;
  logic             ras_push;
  logic             uf_next;
  logic             uf_reg;

  // Stack bookkeeping for a winning jump: pop (if is_ret) then push (if is_call).
  always_comb begin
    jump_tgt     = bus.jump_target;
    ras_ptr_next = ras_ptr;
    ras_cnt_next = ras_cnt;
    push_idx     = ras_ptr;
    ras_push     = 1'b0;
    uf_next      = 1'b0;
    if (valid_reg && !bus.trap && bus.jump_valid) begin
      if (bus.is_ret) begin
        if (ras_cnt != '0) begin
          jump_tgt     = ras_mem[ras_ptr - PTR_W'(1)];
          ras_ptr_next = ras_ptr - PTR_W'(1);
          ras_cnt_next = ras_cnt - (PTR_W + 1)'(1);
        end else begin
          uf_next = 1'b1;
        end
      end
      if (bus.is_call) begin
        ras_push     = 1'b1;
        push_idx     = ras_ptr_next;
        ras_ptr_next = ras_ptr_next + PTR_W'(1);
        // A full stack overwrites its oldest slot, so the depth saturates.
        if (ras_cnt_next != (PTR_W + 1)'(RAS_DEPTH)) begin
          ras_cnt_next = ras_cnt_next + (PTR_W + 1)'(1);
        end
      end
    end
  end

  // Stack pointer, occupancy and underflow pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      uf_reg  <= 1'b0;
    end else begin
      ras_ptr <= ras_ptr_next;
      ras_cnt <= ras_cnt_next;
      uf_reg  <= uf_next;
    end
  end

  // Stack storage holds only return addresses, so it needs no reset.
  always_ff @(posedge clk) begin
    if (ras_push) begin
      ras_mem[push_idx] <= step_pc;
    end
  end

  assign bus.ras_underflow = uf_reg;
`else
  assign jump_tgt = bus.jump_target;
`endif

  // Next-PC selection; only redirect targets are alignment-checked.
  always_comb begin
    pc_next   = step_pc;
    mis_next  = 1'b0;
    write_pc  = 1'b1;
    sel_tgt   = '0;
    check_tgt = 1'b0;
    if (bus.trap) begin
      pc_next = TRAP_VECTOR;
    end else if (bus.jump_valid) begin
      sel_tgt   = jump_tgt;
      check_tgt = 1'b1;
    end else if (bus.branch_taken) begin
      sel_tgt   = bus.branch_target;
      check_tgt = 1'b1;
    end else if (bus.stall) begin
      pc_next  = pc_reg;
      write_pc = 1'b0;
    end
    if (check_tgt) begin
      if (sel_tgt[1:0] != 2'b00) begin
        pc_next  = TRAP_VECTOR;
        mis_next = 1'b1;
      end else begin
        pc_next = sel_tgt;
      end
    end
  end

  // PC state; the first edge after reset is a bubble that only raises pc_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg    <= RESET_VECTOR;
      valid_reg <= 1'b0;
      mis_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else if (!valid_reg) begin
      valid_reg <= 1'b1;
      mis_reg   <= 1'b0;
    end else begin
      pc_reg  <= pc_next;
      mis_reg <= mis_next;
      if (write_pc) begin
        cnt_reg <= sat_inc(cnt_reg);
      end
    end
  end

  assign bus.pc_out     = pc_reg;
  assign bus.pc_valid   = valid_reg;
  assign bus.misaligned = mis_reg;
  assign bus.pc_count   = cnt_reg;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter stage for the single-cycle RISC-V core; successor to the plain clocked PC register.
- Owns next-PC selection: sequential increment, branch/jump redirect, trap vectoring, stall hold, and misalignment detection.
- Also keeps a count of PC advances.
- Feeds instruction memory address; redirect inputs come from the branch/ALU stage.

Parameters:
- WIDTH, 64, PC and target width in bits.
- RESET_VECTOR, 64'h0, PC value loaded on reset.
- TRAP_VECTOR, 64'h100, PC loaded on trap or misaligned redirect.
- STEP, 4, sequential increment in bytes.
- CNT_W, 32, width of advance counter.
- RAS_DEPTH, 4, return-address-stack entries (used only with the optional feature); power of 2, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  hold PC this cycle.
- branch_taken  in  1  redirect to branch_target.
- branch_target  in  WIDTH  branch destination.
- jump_valid  in  1  redirect to jump_target (JAL/JALR).
- jump_target  in  WIDTH  jump destination.
- trap  in  1  redirect to TRAP_VECTOR.
- pc_out  out  WIDTH  current PC (registered).
- pc_valid  out  1  pc_out is a fetchable address.
- misaligned  out  1  one-cycle pulse: selected redirect target was misaligned.
- pc_count  out  CNT_W  number of PC updates since reset.
- Ports present only with RAS_EN:
  - is_call  in  1  qualifies jump_valid as a call.
  - is_ret  in  1  qualifies jump_valid as a return.
  - ras_underflow  out  1  one-cycle pulse on pop of an empty stack.

Behaviour:
- Reset (reset=0, async):
  - pc_out=RESET_VECTOR, pc_valid=0, misaligned=0, pc_count=0.
  - RAS emptied; ras_underflow=0.
  - Reset mid-operation discards any pending redirect.
- First rising edge after reset deasserts:
  - pc_valid<=1, pc_out stays RESET_VECTOR (one bubble cycle), pc_count unchanged.
  - Stall, redirect and trap inputs are ignored on this edge.
- Subsequent edges, priority from highest to lowest:
  1. trap: pc_out<=TRAP_VECTOR.
  2. jump_valid: pc_out<=jump_target.
  3. branch_taken: pc_out<=branch_target.
  4. stall: pc_out holds.
  5. otherwise: pc_out<=pc_out+STEP.
- Redirects and trap override stall.
- Alignment check:
  - A selected target with target[1:0]!=0 is misaligned.
  - pc_out<=TRAP_VECTOR and misaligned pulses 1 for one cycle.
  - Only the winning target is checked; the check never applies to trap.
- Arithmetic:
  - pc_out+STEP wraps modulo 2^WIDTH with no flag.
  - pc_count increments on every edge where pc_out is written (any case except stall and the bubble edge).
  - pc_count saturates at all-ones.
- pc_valid stays 1 until the next reset.
- No combinational path from any input to pc_out.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined: a RAS_DEPTH-entry circular return-address stack is built.
  - jump_valid & is_call pushes pc_out+STEP.
  - jump_valid & is_ret pops; the popped address replaces jump_target as the redirect target.
  - Push when full overwrites the oldest entry; the count stays at RAS_DEPTH.
  - Pop when empty uses jump_target and pulses ras_underflow.
  - is_call & is_ret together: pop first, then push, so the top entry is replaced and the count is unchanged.
  - trap and stall never modify the stack.
  - A push or pop whose jump loses priority to trap is discarded.
- Undefined: is_call, is_ret and ras_underflow ports are absent; jumps always use jump_target.

Test Plan:
- Reset/bubble: hold reset=0, then release. Require pc_out=0x0 and pc_valid=0 during reset. After the 1st edge, pc_valid=1 and pc_out=0x0. After the 2nd edge, pc_out=0x4 and pc_count=1.
- Async reset mid-run: pulse reset=0 for 3 ns between edges while pc_out=0x20. Require pc_out=0x0 and pc_count=0 immediately, with no clock edge needed.
- Priority: in one cycle, stall=1, branch_taken=1 (target 0x400) and jump_valid=1 (target 0x800). Require pc_out=0x800. Next cycle add trap=1; require pc_out=0x100.
- Stall/wrap: set pc_out to 0xFFFF_FFFF_FFFF_FFFC via a jump, then step. Require pc_out=0x0. With stall=1 for 3 cycles, pc_out holds and pc_count does not change.
- Misaligned: branch_taken=1 with target 0x402. Require pc_out=0x100 and a single-cycle misaligned=1.
- RAS (PC_RAS_EN, RAS_DEPTH=4):
  - Call from 0x10 → push 0x14; ret → pc_out=0x14.
  - Five calls, then five rets: the 5th ret pulses ras_underflow and uses jump_target.
